// File: rtl/multipath_channel_gen_pkg.sv
// Voice-link common package: sample width, signed sample type, attenuation
// shift width, echo buffer geometry and the channel-generator fill/run states.
package multipath_channel_gen_pkg;

  localparam int VL_DATA_W    = 8;
  localparam int VL_ATTEN_W   = 2;
  localparam int VL_MAX_DELAY = 16;
  localparam int VL_ADDR_W    = 4;

  typedef logic signed [VL_DATA_W-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/multipath_channel_gen_if.sv
// Sample stream bundle between the voice source, the channel generator and
// the downstream multipath combiner.
interface multipath_channel_gen_if
  import multipath_channel_gen_pkg::*;
#(
  parameter int DATA_W = VL_DATA_W
) ();

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_sample;
  logic                     out_valid;
  logic signed [DATA_W-1:0] pathone;
  logic signed [DATA_W-1:0] pathtwo;
  logic                     primed;

  modport master (
    output in_valid, in_sample,
    input  out_valid, pathone, pathtwo, primed
  );

  modport slave (
    input  in_valid, in_sample,
    output out_valid, pathone, pathtwo, primed
  );

endinterface

// File: rtl/multipath_channel_gen_echo_delay_ram.sv
// Echo delay RAM: single clock, synchronous write, addressed read that returns
// the contents from before any write landing on the same edge.
module echo_delay_ram
  import multipath_channel_gen_pkg::*;
#(
  parameter int DATA_W = VL_DATA_W,
  parameter int DEPTH  = VL_MAX_DELAY,
  parameter int ADDR_W = VL_ADDR_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Store the accepted sample; contents survive reset and clear on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/multipath_channel_gen.sv
// Two-path channel emulator: direct branch and delayed echo branch, each with
// an arithmetic-shift attenuator, feeding the MISO multipath combiner.
module multipath_channel_gen
  import multipath_channel_gen_pkg::*;
#(
  parameter int DATA_W    = VL_DATA_W,
  parameter int MAX_DELAY = VL_MAX_DELAY,
  parameter int ADDR_W    = VL_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [ADDR_W-1:0]     delay_sel,
  input  logic [VL_ATTEN_W-1:0] atten_one,
  input  logic [VL_ATTEN_W-1:0] atten_two,
  multipath_channel_gen_if.slave bus
);

  localparam int FILL_W = ADDR_W + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_DELAY);

  state_t                   state_q;
  state_t                   state_next;
  state_t                   sample_state;
  logic                     accept;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        rd_addr;
  logic [FILL_W-1:0]        fill_cnt;
  logic [FILL_W-1:0]        fill_next;
  logic [FILL_W-1:0]        delay_d;
  logic signed [DATA_W-1:0] echo;
  logic signed [DATA_W-1:0] echo_shifted;
  logic signed [DATA_W-1:0] pathone_next;
  logic signed [DATA_W-1:0] pathtwo_next;
  logic signed [DATA_W-1:0] pathone_q;
  logic signed [DATA_W-1:0] pathtwo_q;
  logic                     out_valid_q;

  echo_delay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DELAY),
    .ADDR_W (ADDR_W)
  ) u_echo_delay_ram (
    .clk     (clk),
    .we      (accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_sample),
    .rd_addr (rd_addr),
    .rd_data (echo)
  );

  // Fill/run decision for the sample being accepted, using the pre-write fill count.
  always_comb begin
    accept       = bus.in_valid && !clear;
    delay_d      = FILL_W'(delay_sel) + FILL_W'(1);
    rd_addr      = wr_ptr - delay_sel - ADDR_W'(1);
    sample_state = (fill_cnt >= delay_d) ? RUN : FILL;
    state_next   = state_q;
    if (clear) begin
      state_next = FILL;
    end else if (accept) begin
      state_next = sample_state;
    end
  end

  // State register; its value is what the primed output reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_next;
    end
  end

  // Attenuators and fill saturation for the sample being accepted.
  always_comb begin
    fill_next    = (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + FILL_W'(1);
    pathone_next = bus.in_sample >>> atten_one;
    echo_shifted = echo >>> atten_two;
    pathtwo_next = '0;
    if (sample_state == RUN) begin
      pathtwo_next = echo_shifted;
    end
  end

  // Pointer, fill count and registered branch outputs; clear beats in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      pathone_q   <= '0;
      pathtwo_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      pathone_q   <= '0;
      pathtwo_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        wr_ptr    <= wr_ptr + ADDR_W'(1);
        fill_cnt  <= fill_next;
        pathone_q <= pathone_next;
        pathtwo_q <= pathtwo_next;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pathone   = pathone_q;
  assign bus.pathtwo   = pathtwo_q;
  assign bus.primed    = (state_q == RUN);

endmodule

// File: tb/tb_multipath_channel_gen.sv
// Self-checking bench for multipath_channel_gen against a sample-history model.
module tb_multipath_channel_gen;
  import multipath_channel_gen_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [3:0] delay_sel;
  logic [1:0] atten_one;
  logic [1:0] atten_two;

  int compare_count;
  int mismatch_count;

  // Reference model: every sample accepted since the last clear or reset.
  int hist[$];
  int exp_one;
  int exp_two;
  int exp_valid;
  int exp_primed;

  multipath_channel_gen_if #(.DATA_W(8)) bus_if ();

  multipath_channel_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .delay_sel (delay_sel),
    .atten_one (atten_one),
    .atten_two (atten_two),
    .bus       (bus_if)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int floorShift(input int v, input int k);
    int p;
    int q;
    p = 1 << k;
    q = v / p;
    if ((v % p) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compare_count++;
    if (observed != expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".out_valid"}, int'(bus_if.out_valid), exp_valid);
    checkOutput({tag, ".pathone"}, int'(bus_if.pathone), exp_one);
    checkOutput({tag, ".pathtwo"}, int'(bus_if.pathtwo), exp_two);
    checkOutput({tag, ".primed"}, int'(bus_if.primed), exp_primed);
  endtask

  task automatic modelReset();
    hist.delete();
    exp_one    = 0;
    exp_two    = 0;
    exp_valid  = 0;
    exp_primed = 0;
  endtask

  task automatic modelStep(input bit valid, input int sample, input int dsel,
                           input int a1, input int a2, input bit clr);
    int d;
    int n;
    if (clr) begin
      modelReset();
    end else if (valid) begin
      d = dsel + 1;
      n = hist.size();
      exp_one    = floorShift(sample, a1);
      exp_two    = (n >= d) ? floorShift(hist[n-d], a2) : 0;
      exp_primed = (n >= d) ? 1 : 0;
      exp_valid  = 1;
      hist.push_back(sample);
    end else begin
      exp_valid = 0;
    end
  endtask

  // Called at a falling edge: drive one cycle, advance the model, check at the next falling edge.
  task automatic applyStimulus(input string tag, input bit valid, input int sample, input int dsel,
                               input int a1, input int a2, input bit clr);
    bus_if.in_valid  = valid;
    bus_if.in_sample = 8'(sample);
    delay_sel        = 4'(dsel);
    atten_one        = 2'(a1);
    atten_two        = 2'(a2);
    clear            = clr;
    modelStep(valid, sample, dsel, a1, a2, clr);
    @(posedge clk);
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    int s;
    int dsel;
    compare_count    = 0;
    mismatch_count   = 0;
    rst_n            = 1'b0;
    clear            = 1'b0;
    delay_sel        = '0;
    atten_one        = '0;
    atten_two        = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_sample = '0;
    modelReset();

    repeat (2) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;

    $display("[TB] basic delay D=3");
    for (int i = 1; i <= 5; i++) applyStimulus("basic", 1'b1, 10 * i, 2, 0, 0, 1'b0);
    applyStimulus("basic_idle", 1'b0, 0, 2, 0, 0, 1'b0);

    $display("[TB] attenuation extremes");
    applyStimulus("att_clear", 1'b0, 0, 0, 0, 0, 1'b1);
    applyStimulus("att_neg_fs", 1'b1, -128, 0, 1, 0, 1'b0);
    applyStimulus("att_pos_fs", 1'b1, 127, 0, 0, 0, 1'b0);
    applyStimulus("att_echo127", 1'b1, 5, 0, 0, 2, 1'b0);
    applyStimulus("att_minus1", 1'b1, -1, 0, 1, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      s = ($urandom_range(0, 1) == 1) ? 127 : -128;
      applyStimulus("att_sum", 1'b1, s, $urandom_range(0, 3), 1, 1, 1'b0);
      s = int'(bus_if.pathone) + int'(bus_if.pathtwo);
      checkOutput("sum_in_range", int'(s >= -128 && s <= 127), 1);
    end

    $display("[TB] wrap-around D=16, back-to-back then gapped");
    applyStimulus("wrap_clear", 1'b0, 0, 15, 0, 0, 1'b1);
    for (int i = 1; i <= 40; i++) applyStimulus("wrap", 1'b1, i, 15, 0, 0, 1'b0);
    checkOutput("wrap_last_pathtwo", int'(bus_if.pathtwo), 24);
    applyStimulus("wrap_gap_clear", 1'b0, 0, 15, 0, 0, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      applyStimulus("wrap_gap", 1'b1, i, 15, 0, 0, 1'b0);
      applyStimulus("wrap_gap_idle", 1'b0, 0, 15, 0, 0, 1'b0);
      applyStimulus("wrap_gap_idle", 1'b0, 0, 15, 0, 0, 1'b0);
    end
    checkOutput("wrap_gap_last_pathtwo", int'(bus_if.pathtwo), 24);

    $display("[TB] delay change mid-stream");
    applyStimulus("dchg_clear", 1'b0, 0, 1, 0, 0, 1'b1);
    for (int i = 1; i <= 3; i++) applyStimulus("dchg_d2", 1'b1, 100 + i, 1, 0, 0, 1'b0);
    for (int i = 4; i <= 9; i++) applyStimulus("dchg_d5", 1'b1, 100 + i, 4, 0, 0, 1'b0);

    $display("[TB] clear collides with in_valid");
    applyStimulus("clr_hit", 1'b1, 99, 2, 0, 0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus("clr_after", 1'b1, i, 2, 0, 0, 1'b0);
      checkOutput("clr_no99", int'(bus_if.pathtwo == 8'sd99), 0);
    end

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 1; i <= 5; i++) applyStimulus("rst_pre", 1'b1, 60 + i, 1, 0, 0, 1'b0);
    bus_if.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("rst_async");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkAll("rst_released");
    for (int i = 1; i <= 6; i++) applyStimulus("rst_post", 1'b1, 70 + i, 1, 0, 0, 1'b0);

    $display("[TB] randomized traffic");
    dsel = $urandom_range(0, 15);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) dsel = $urandom_range(0, 15);
      applyStimulus("rand", ($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)) - 128,
                    dsel, $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/multipath_channel_gen.md
# multipath_channel_gen

Two-path channel emulator that sits directly upstream of the MISO multipath combiner in the voice-link simulation. It takes one signed 8-bit voice sample stream and produces the two signed 8-bit branch signals the combiner consumes: a direct path and an echo path. Each branch has a programmable arithmetic-shift attenuation, and the echo path has a programmable sample delay held in a circular buffer.

## Interface
Parameters:
- DATA_W, 8, sample width (signed two's complement)
- MAX_DELAY, 16, echo buffer depth in samples (power of two)
- ADDR_W, 4, log2(MAX_DELAY)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low
- clear  in  1  synchronous flush of pointer and fill state
- in_valid  in  1  sample strobe; any duty cycle up to every cycle
- in_sample  in  DATA_W  signed input sample
- delay_sel  in  ADDR_W  echo delay D = delay_sel+1 samples (1..MAX_DELAY)
- atten_one  in  2  direct-path right shift, 0..3
- atten_two  in  2  echo-path right shift, 0..3
- out_valid  out  1  one-cycle strobe: pathone/pathtwo updated
- pathone  out  DATA_W  direct branch to combiner
- pathtwo  out  DATA_W  delayed branch to combiner
- primed  out  1  high when the echo path carries real (delayed) data

## Operation
- Storage is a MAX_DELAY-entry memory, a write pointer wr_ptr (ADDR_W bits, wraps modulo MAX_DELAY), and a fill counter fill_cnt (0..MAX_DELAY, saturating).
- The block has two states:
  - FILL: fill_cnt < D.
  - RUN: fill_cnt >= D.
  - State is evaluated at each accepted sample, using the fill_cnt value from before that sample's write.
- On each accepted in_valid (clear low):
  - read echo = mem[(wr_ptr - D) mod MAX_DELAY], read-before-write. With D = MAX_DELAY, this returns the entry about to be overwritten.
  - mem[wr_ptr] <= in_sample.
  - wr_ptr <= wr_ptr + 1.
  - fill_cnt <= min(fill_cnt + 1, MAX_DELAY).
  - pathone <= in_sample >>> atten_one (arithmetic shift; -1 stays -1).
  - pathtwo <= (RUN) ? echo >>> atten_two : 0.
  - primed <= RUN.
  - out_valid <= 1.
- Between accepted samples:
  - out_valid = 0.
  - pathone, pathtwo and primed hold their values.
- delay_sel, atten_one and atten_two are sampled only on accepted samples. Changes take effect on the next sample. If a new D exceeds fill_cnt, the block returns to FILL and pathtwo outputs 0 until fill_cnt reaches the new D. Memory contents are not cleared.
- clear has priority over in_valid:
  - a sample presented in the same cycle is discarded.
  - wr_ptr, fill_cnt, pathone, pathtwo, primed and out_valid go to 0 on the next edge.
  - memory is not cleared.
- Headroom rule for the downstream sum: with atten_one >= 1 and atten_two >= 1, pathone + pathtwo always fits in DATA_W bits. With shift 0 on either path, overflow is the combiner's responsibility.

## Timing
- Reset values: pathone=0, pathtwo=0, out_valid=0, primed=0, wr_ptr=0, fill_cnt=0.
- Latency: one clock from in_valid to out_valid and updated outputs. Fully pipelined; one sample per cycle is sustained.
- Echo delay is counted in accepted samples, not clock cycles.
- Reset mid-stream: outputs are 0 immediately on rst_n low. After release, the block behaves exactly as from power-up: D accepted samples of zero echo.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package (voice-link common): DATA_W, the signed sample typedef, and the attenuation-shift width constant. The downstream combiner uses the same package.
- One natural sub-module: echo_delay_ram. It is a MAX_DELAY x DATA_W single-clock RAM with synchronous write and read-before-write addressed read. Pointer, fill, FSM and shifters stay in the top.

## Test plan
- Basic delay: delay_sel=2 (D=3), atten 0/0, back-to-back samples 10,20,30,40,50.
  - pathone = 10,20,30,40,50.
  - pathtwo = 0,0,0,10,20.
  - primed rises with the 4th out_valid.
- Attenuation extremes:
  - atten_one=1 on -128 gives -64.
  - atten_two=2 with echo 127 gives 31.
  - atten_one=1 on -1 gives -1.
  - Both shifts 1 with input ±full-scale: the pathone+pathtwo sum stays in [-128,127].
- Wrap-around: delay_sel=15 (D=16), ramp 1..40.
  - pathtwo is 0 for the first 16 samples.
  - pathtwo = 1 at sample index 16 and 24 at index 39.
  - Repeat with in_valid gapped (every 3rd cycle): identical sample-domain results.
- Delay change mid-stream: D=2 for 3 samples, then delay_sel=4 (D=5).
  - primed drops.
  - pathtwo = 0 until the 6th total sample, then resumes correctly aligned.
- Clear vs in_valid collision: assert clear together with in_valid=1, sample 99.
  - No out_valid.
  - All outputs 0.
  - The next D samples produce zero echo.
  - 99 never appears on pathtwo.
- Reset mid-operation: pull rst_n low asynchronously (off clock edge) after 5 samples.
  - Outputs are 0 before the next edge.
  - After release, zero echo persists for D samples.
